// File: rtl/core_pkg.sv
// core_pkg: shared ALU op codes, opcode constants, instruction classes and FSM states
package core_pkg;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
   } alu_op_t;

   typedef enum logic [3:0] {
      CL_OP, CL_OPIMM, CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_LOAD, CL_STORE, CL_BRANCH, CL_NONE
   } instr_class_t;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_JAL    = 7'h6F;

   // arithmetic op from func3; alt selects SUB/SRA
   function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0:    return alt ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return alt ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   // branch compare op from func3; reserved encodings fall back to EQ
   function automatic alu_op_t br_from_f3(input logic [2:0] f3);
      case (f3)
         3'd1:    return ALU_NE;
         3'd4:    return ALU_LT;
         3'd5:    return ALU_GE;
         3'd6:    return ALU_LTU;
         3'd7:    return ALU_GEU;
         default: return ALU_EQ;
      endcase
   endfunction

endpackage

// File: rtl/rv_decoder.sv
// rv_decoder: combinational RV decode of instruction class, ALU op and illegal flag
module rv_decoder
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]  i_instr,
   output instr_class_t o_class,
   output logic [3:0]   o_alu_sel,
   output logic         o_illegal
);

   logic [2:0] w_f3;
   logic [6:0] w_f7;
   logic [6:0] w_sh7;
   logic       w_shift;
   logic       w_unused;

   assign w_f3     = i_instr[14:12];
   assign w_f7     = i_instr[31:25];
   // on RV64 bit 25 is part of the 6-bit shift amount, not func7
   assign w_sh7    = (XLEN == 64) ? {i_instr[31:26], 1'b0} : i_instr[31:25];
   assign w_shift  = (w_f3 == 3'd1) || (w_f3 == 3'd5);
   assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

   // classify opcode and pick the ALU operation
   always_comb begin
      o_class   = CL_NONE;
      o_alu_sel = ALU_ADD;
      o_illegal = 1'b0;
      case (i_instr[6:0])
         OPC_OP: begin
            o_class   = CL_OP;
            o_alu_sel = alu_from_f3(w_f3, w_f7[5]);
            o_illegal = !((w_f7 == 7'h00) || ((w_f7 == 7'h20) && ((w_f3 == 3'd0) || (w_f3 == 3'd5))));
         end
         OPC_OPIMM: begin
            o_class   = CL_OPIMM;
            o_alu_sel = alu_from_f3(w_f3, w_shift && w_sh7[5]);
            o_illegal = w_shift && !((w_sh7 == 7'h00) || ((w_sh7 == 7'h20) && (w_f3 == 3'd5)));
         end
         OPC_LUI:    o_class = CL_LUI;
         OPC_AUIPC:  o_class = CL_AUIPC;
         OPC_JAL:    o_class = CL_JAL;
         OPC_JALR:   o_class = CL_JALR;
         OPC_LOAD:   o_class = CL_LOAD;
         OPC_STORE:  o_class = CL_STORE;
         OPC_BRANCH: begin
            o_class   = CL_BRANCH;
            o_alu_sel = br_from_f3(w_f3);
         end
         default:    o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle RV control FSM with memory timeout and retire counter
module mc_controller
   import core_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CNT_W  = 32,
   parameter int MEM_TO = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             br_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic [1:0]       rd_data_sel,
   output logic [3:0]       alu_sel,
   output logic             rf_en,
   output logic             rs1_pc_sel,
   output logic             rs2_imm_sel,
   output logic             trap,
   output logic [CNT_W-1:0] instret
);

   localparam int WW = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;

   state_t           r_state;
   state_t           w_next;
   logic [WW-1:0]    r_wait;
   logic [CNT_W-1:0] r_instret;
   instr_class_t     w_class;
   logic [3:0]       w_alu;
   logic             w_illegal;
   logic             w_alu_act;
   logic             w_waiting;
   logic             w_timeout;
   logic             w_jump;

   rv_decoder #(.XLEN(XLEN)) u_dec (
      .i_instr   (instr),
      .o_class   (w_class),
      .o_alu_sel (w_alu),
      .o_illegal (w_illegal)
   );

   assign w_alu_act    = (r_state == EXEC) || (r_state == MEM) || (r_state == WB);
   assign w_jump       = (w_class == CL_JAL) || (w_class == CL_JALR);
   assign mem_req      = (r_state == FETCH) || (r_state == MEM);
   assign mem_addr_sel = (r_state == MEM);
   assign mem_we       = (r_state == MEM) && (w_class == CL_STORE);
   assign ir_we        = (r_state == FETCH) && mem_ready;
   assign rf_en        = (r_state == WB);
   assign trap         = (r_state == TRAP);
   assign alu_sel      = w_alu_act ? w_alu : 4'd0;
   assign rs1_pc_sel   = w_alu_act && (w_class == CL_AUIPC);
   assign rs2_imm_sel  = w_alu_act && ((w_class == CL_OP) || (w_class == CL_BRANCH));
   assign pc_we        = ((r_state == EXEC) && (w_class == CL_BRANCH)) ||
                         ((r_state == MEM) && (w_class == CL_STORE) && mem_ready) || (r_state == WB);
   assign pc_sel       = ((r_state == EXEC) && (w_class == CL_BRANCH)) ? {1'b0, br_taken} :
                         ((r_state == WB) && (w_class == CL_JAL))      ? 2'd1 :
                         ((r_state == WB) && (w_class == CL_JALR))     ? 2'd2 : 2'd0;
   assign rd_data_sel  = (r_state != WB)        ? 2'd0 :
                         (w_class == CL_LOAD)   ? 2'd1 :
                         w_jump                 ? 2'd2 :
                         (w_class == CL_LUI)    ? 2'd3 : 2'd0;
   assign w_waiting    = mem_req && !mem_ready;
   assign w_timeout    = (MEM_TO != 0) && w_waiting && (r_wait == WW'(MEM_TO - 1));
   assign instret      = r_instret;

   // next-state selection
   always_comb begin
      w_next = TRAP;
      case (r_state)
         FETCH:   w_next = w_timeout ? TRAP : (mem_ready ? DECODE : FETCH);
         DECODE:  w_next = w_illegal ? TRAP : EXEC;
         EXEC:    w_next = (w_class == CL_BRANCH) ? FETCH :
                           ((w_class == CL_LOAD) || (w_class == CL_STORE)) ? MEM : WB;
         MEM:     w_next = w_timeout ? TRAP : (!mem_ready ? MEM : ((w_class == CL_STORE) ? FETCH : WB));
         WB:      w_next = FETCH;
         default: w_next = TRAP;
      endcase
   end

   // state, wait counter (cleared on every transition) and retire counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= FETCH;
         r_wait    <= '0;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         r_wait  <= (w_waiting && (w_next == r_state)) ? r_wait + 1'b1 : '0;
         if ((w_next == FETCH) && w_alu_act)
            r_instret <= r_instret + 1'b1;
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed vector and sequence checks of mc_controller
module tb_mc_controller;
   import core_pkg::*;

   localparam logic [1:0] K_WB = 2'd0, K_LD = 2'd1, K_ST = 2'd2, K_BR = 2'd3;

   typedef struct {
      logic [31:0] ins;
      logic        br;
      logic        ill;
      logic [1:0]  kind;
      logic [3:0]  alu;
      logic        rs1pc;
      logic        rs2imm;
      logic [1:0]  pcsel;
      logic [1:0]  rdsel;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = 32'h0;
   logic        br_taken = 1'b0;
   logic        mem_ready = 1'b1;
   logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_en, rs1_pc_sel, rs2_imm_sel, trap;
   logic [1:0]  pc_sel, rd_data_sel;
   logic [3:0]  alu_sel;
   logic [31:0] instret;
   int          n_tests = 0;
   int          n_fail = 0;
   vec_t        vt[20];

   mc_controller #(.XLEN(32), .CNT_W(32), .MEM_TO(4)) dut (
      .clk(clk), .rst(rst), .instr(instr), .br_taken(br_taken), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
      .pc_we(pc_we), .pc_sel(pc_sel), .rd_data_sel(rd_data_sel), .alu_sel(alu_sel),
      .rf_en(rf_en), .rs1_pc_sel(rs1_pc_sel), .rs2_imm_sel(rs2_imm_sel), .trap(trap),
      .instret(instret)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic chk_idle(input string name);
      chk(name, {28'd0, mem_req, ir_we, pc_we, rf_en, mem_we}, 32'd0);
   endtask

   task automatic run_addi;
      instr = 32'h00500093;
      mem_ready = 1'b1;
      repeat (4) tick();
   endtask

   initial begin
      vt[0]  = '{32'h00500093, 1'b0, 1'b0, K_WB, ALU_ADD,  1'b0, 1'b0, 2'd0, 2'd0};
      vt[1]  = '{32'h402081B3, 1'b0, 1'b0, K_WB, ALU_SUB,  1'b0, 1'b1, 2'd0, 2'd0};
      vt[2]  = '{32'h022081B3, 1'b0, 1'b1, K_WB, ALU_ADD,  1'b0, 1'b0, 2'd0, 2'd0};
      vt[3]  = '{32'h4020D1B3, 1'b0, 1'b0, K_WB, ALU_SRA,  1'b0, 1'b1, 2'd0, 2'd0};
      vt[4]  = '{32'h4030D093, 1'b0, 1'b0, K_WB, ALU_SRA,  1'b0, 1'b0, 2'd0, 2'd0};
      vt[5]  = '{32'h40309093, 1'b0, 1'b1, K_WB, ALU_ADD,  1'b0, 1'b0, 2'd0, 2'd0};
      vt[6]  = '{32'h4000F093, 1'b0, 1'b0, K_WB, ALU_AND,  1'b0, 1'b0, 2'd0, 2'd0};
      vt[7]  = '{32'h123450B7, 1'b0, 1'b0, K_WB, ALU_ADD,  1'b0, 1'b0, 2'd0, 2'd3};
      vt[8]  = '{32'h00001097, 1'b0, 1'b0, K_WB, ALU_ADD,  1'b1, 1'b0, 2'd0, 2'd0};
      vt[9]  = '{32'h008000EF, 1'b0, 1'b0, K_WB, ALU_ADD,  1'b0, 1'b0, 2'd1, 2'd2};
      vt[10] = '{32'h000100E7, 1'b0, 1'b0, K_WB, ALU_ADD,  1'b0, 1'b0, 2'd2, 2'd2};
      vt[11] = '{32'h00012083, 1'b0, 1'b0, K_LD, ALU_ADD,  1'b0, 1'b0, 2'd0, 2'd1};
      vt[12] = '{32'h00112023, 1'b0, 1'b0, K_ST, ALU_ADD,  1'b0, 1'b0, 2'd0, 2'd0};
      vt[13] = '{32'h00208063, 1'b1, 1'b0, K_BR, ALU_EQ,   1'b0, 1'b1, 2'd1, 2'd0};
      vt[14] = '{32'h00208063, 1'b0, 1'b0, K_BR, ALU_EQ,   1'b0, 1'b1, 2'd0, 2'd0};
      vt[15] = '{32'h0020C063, 1'b1, 1'b0, K_BR, ALU_LT,   1'b0, 1'b1, 2'd1, 2'd0};
      vt[16] = '{32'h0020F063, 1'b0, 1'b0, K_BR, ALU_GEU,  1'b0, 1'b1, 2'd0, 2'd0};
      vt[17] = '{32'h00000000, 1'b0, 1'b1, K_WB, ALU_ADD,  1'b0, 1'b0, 2'd0, 2'd0};
      vt[18] = '{32'h0020C1B3, 1'b0, 1'b0, K_WB, ALU_XOR,  1'b0, 1'b1, 2'd0, 2'd0};
      vt[19] = '{32'h4020C1B3, 1'b0, 1'b1, K_WB, ALU_ADD,  1'b0, 1'b0, 2'd0, 2'd0};

      for (int i = 0; i < 20; i++) begin
         instr = vt[i].ins;
         br_taken = vt[i].br;
         mem_ready = 1'b1;
         do_reset();
         chk($sformatf("v%0d fetch instret", i), instret, 32'd0);
         chk($sformatf("v%0d fetch req/ir/addr", i), {29'd0, mem_req, ir_we, mem_addr_sel}, 32'b110);
         tick();
         chk_idle($sformatf("v%0d decode idle", i));
         tick();
         if (vt[i].ill) begin
            chk($sformatf("v%0d trap", i), {31'd0, trap}, 32'd1);
            chk_idle($sformatf("v%0d trap idle", i));
            continue;
         end
         chk($sformatf("v%0d exec alu_sel", i), {28'd0, alu_sel}, {28'd0, vt[i].alu});
         chk($sformatf("v%0d exec rs sels", i), {30'd0, rs1_pc_sel, rs2_imm_sel}, {30'd0, vt[i].rs1pc, vt[i].rs2imm});
         chk($sformatf("v%0d exec rf_en/trap", i), {30'd0, rf_en, trap}, 32'd0);
         if (vt[i].kind == K_BR) begin
            chk($sformatf("v%0d br pc_we/sel/req", i), {28'd0, pc_we, pc_sel, mem_req}, {28'd0, 1'b1, vt[i].pcsel, 1'b0});
         end else if (vt[i].kind == K_WB) begin
            chk($sformatf("v%0d exec pc_we", i), {31'd0, pc_we}, 32'd0);
            tick();
            chk($sformatf("v%0d wb rf/pcwe/we", i), {29'd0, rf_en, pc_we, mem_we}, 32'b110);
            chk($sformatf("v%0d wb pc_sel", i), {30'd0, pc_sel}, {30'd0, vt[i].pcsel});
            chk($sformatf("v%0d wb rd_data_sel", i), {30'd0, rd_data_sel}, {30'd0, vt[i].rdsel});
         end else begin
            tick();
            chk($sformatf("v%0d mem req/addr", i), {30'd0, mem_req, mem_addr_sel}, 32'b11);
            chk($sformatf("v%0d mem we/pcwe/rf", i), {29'd0, mem_we, pc_we, rf_en},
                (vt[i].kind == K_ST) ? 32'b110 : 32'b000);
            if (vt[i].kind == K_LD) begin
               tick();
               chk($sformatf("v%0d ld wb rf/pcwe/sel", i), {28'd0, rf_en, pc_we, pc_sel}, 32'b1100);
               chk($sformatf("v%0d ld wb rd_data_sel", i), {30'd0, rd_data_sel}, {30'd0, vt[i].rdsel});
            end
         end
         tick();
         chk($sformatf("v%0d retire instret", i), instret, 32'd1);
         chk($sformatf("v%0d back in fetch", i), {30'd0, mem_req, rf_en}, 32'b10);
      end

      // load with three not-ready memory cycles
      instr = 32'h00012083;
      mem_ready = 1'b1;
      do_reset();
      tick();
      tick();
      mem_ready = 1'b0;
      tick();
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("lw wait c%0d req/addr/trap", c), {29'd0, mem_req, mem_addr_sel, trap}, 32'b110);
         mem_ready = (c == 3);
         tick();
      end
      chk("lw wb rf/rdsel", {29'd0, rf_en, rd_data_sel}, 32'b101);
      tick();
      chk("lw instret", instret, 32'd1);

      // illegal instruction: trap is sticky and all enables stay low
      instr = 32'h00000000;
      mem_ready = 1'b1;
      do_reset();
      tick();
      tick();
      for (int c = 0; c < 5; c++) begin
         mem_ready = c[0];
         chk($sformatf("sticky trap c%0d", c), {31'd0, trap}, 32'd1);
         chk_idle($sformatf("sticky idle c%0d", c));
         tick();
      end
      do_reset();
      chk("post-trap reset trap/req", {30'd0, trap, mem_req}, 32'b01);

      // retire count over three instructions, then fetch timeout
      do_reset();
      for (int n = 1; n <= 3; n++) begin
         run_addi();
         chk($sformatf("instret after %0d", n), instret, n);
      end
      mem_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("fetch wait c%0d no trap", c), {30'd0, trap, mem_req}, 32'b01);
      end
      tick();
      chk("fetch timeout trap", {30'd0, trap, mem_req}, 32'b10);
      chk("trap keeps instret", instret, 32'd3);
      #3;
      rst = 1'b1;
      #1;
      chk("async rst trap/req", {30'd0, trap, mem_req}, 32'b01);
      chk("async rst instret", instret, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mem_ready = 1'b1;
      #1;
      chk("restart ir_we", {31'd0, ir_we}, 32'd1);

      // reset in the middle of a memory access
      instr = 32'h00112023;
      mem_ready = 1'b1;
      do_reset();
      tick();
      tick();
      mem_ready = 1'b0;
      tick();
      chk("mid-access mem_we/addr", {30'd0, mem_we, mem_addr_sel}, 32'b11);
      #2;
      rst = 1'b1;
      #1;
      chk("mid-access rst addr/we/req", {29'd0, mem_addr_sel, mem_we, mem_req}, 32'b001);
      tick();
      rst = 1'b0;

      // store timeout in MEM
      mem_ready = 1'b1;
      tick();
      tick();
      mem_ready = 1'b0;
      tick();
      repeat (4) tick();
      chk("mem timeout trap", {30'd0, trap, mem_req}, 32'b10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
